// File: rtl/turn_sequencer.sv
// Tic-tac-toe turn controller: key validation, write strobes to the
// mark recorder, BCD turn timer, win-check wait and timeout handling.
// Ports: clk, rst (sync, active high); key_code, board, game_state in;
// wr_en/wr_pos/wr_mark to recorder; whos_turn, time_tens/time_ones,
// key_reject, final_state, busy status out. All outputs registered.
module turn_sequencer #(
  parameter int TICKS_PER_SEC   = 10,
  parameter int TURN_SECONDS    = 15,
  parameter int TIMEOUT_FORFEIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic [17:0] board,
  input  logic [1:0]  game_state,
  output logic        wr_en,
  output logic [3:0]  wr_pos,
  output logic [1:0]  wr_mark,
  output logic        whos_turn,
  output logic [3:0]  time_tens,
  output logic [3:0]  time_ones,
  output logic        key_reject,
  output logic [1:0]  final_state,
  output logic        busy
);

  typedef enum logic [1:0] {
    TURN, WRITE, CHECK, DONE
  } state_t;

  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] RT = 4'(TURN_SECONDS / 10);
  localparam logic [3:0] RO = 4'(TURN_SECONDS % 10);

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    key_prev;

  logic key_ev;
  logic cell_free;
  logic key_ok;
  logic tick;
  logic timeout;

  always_comb begin
    cell_free = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (key_code == 4'(i + 1))
        cell_free = (board[2*i +: 2] == 2'b00);
    end
  end

  assign key_ev  = (key_code != 4'd0) && (key_prev == 4'd0);
  assign key_ok  = key_ev && cell_free;
  assign tick    = (presc == PMAX);
  assign timeout = tick && (time_tens == 4'd0)
                   && (time_ones == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TURN;
      presc       <= '0;
      key_prev    <= 4'd0;
      wr_en       <= 1'b0;
      wr_pos      <= 4'd0;
      wr_mark     <= 2'b00;
      whos_turn   <= 1'b0;
      time_tens   <= RT;
      time_ones   <= RO;
      key_reject  <= 1'b0;
      final_state <= 2'b00;
      busy        <= 1'b0;
    end else begin
      key_prev   <= key_code;
      wr_en      <= 1'b0;
      key_reject <= 1'b0;
      unique case (state)
        TURN: begin
          if (key_ok) begin
            // an accepted key swallows any coincident tick
            wr_pos  <= key_code - 4'd1;
            wr_mark <= whos_turn ? 2'b10 : 2'b01;
            wr_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= WRITE;
          end else begin
            key_reject <= key_ev;
            presc      <= tick ? '0 : presc + 1'b1;
            if (timeout) begin
              if (TIMEOUT_FORFEIT != 0) begin
                final_state <= whos_turn ? 2'b01 : 2'b10;
                state       <= DONE;
              end else begin
                whos_turn <= ~whos_turn;
                time_tens <= RT;
                time_ones <= RO;
                presc     <= '0;
              end
            end else if (tick) begin
              if (time_ones == 4'd0) begin
                time_ones <= 4'd9;
                time_tens <= time_tens - 4'd1;
              end else begin
                time_ones <= time_ones - 4'd1;
              end
            end
          end
        end
        WRITE: state <= CHECK;
        CHECK: begin
          busy <= 1'b0;
          if (game_state != 2'b00) begin
            final_state <= game_state;
            state       <= DONE;
          end else begin
            whos_turn <= ~whos_turn;
            time_tens <= RT;
            time_ones <= RO;
            presc     <= '0;
            state     <= TURN;
          end
        end
        DONE: state <= DONE;
        default: state <= TURN;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: pass-turn and forfeit variants side by side,
// directed scenarios then random keys against a behavioural model.
module tb_turn_sequencer;

  localparam int TPS = 10;
  localparam int TS  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_code = 4'd0;
  logic [17:0] board = 18'd0;
  logic [1:0]  game_state = 2'b00;

  logic       wr_en [2];
  logic [3:0] wr_pos [2];
  logic [1:0] wr_mark [2];
  logic       whos_turn [2];
  logic [3:0] time_tens [2];
  logic [3:0] time_ones [2];
  logic       key_reject [2];
  logic [1:0] final_state [2];
  logic       busy [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  turn_sequencer #(
    .TICKS_PER_SEC(TPS), .TURN_SECONDS(TS), .TIMEOUT_FORFEIT(0)
  ) dut0 (
    .clk(clk), .rst(rst), .key_code(key_code), .board(board),
    .game_state(game_state), .wr_en(wr_en[0]), .wr_pos(wr_pos[0]),
    .wr_mark(wr_mark[0]), .whos_turn(whos_turn[0]),
    .time_tens(time_tens[0]), .time_ones(time_ones[0]),
    .key_reject(key_reject[0]), .final_state(final_state[0]),
    .busy(busy[0])
  );

  turn_sequencer #(
    .TICKS_PER_SEC(TPS), .TURN_SECONDS(TS), .TIMEOUT_FORFEIT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .key_code(key_code), .board(board),
    .game_state(game_state), .wr_en(wr_en[1]), .wr_pos(wr_pos[1]),
    .wr_mark(wr_mark[1]), .whos_turn(whos_turn[1]),
    .time_tens(time_tens[1]), .time_ones(time_ones[1]),
    .key_reject(key_reject[1]), .final_state(final_state[1]),
    .busy(busy[1])
  );

  // reference model: seconds left, cycles into the current second,
  // cycles since a move was accepted (0 = waiting for a move)
  int   m_secs [2];
  int   m_sub [2];
  int   m_after [2];
  bit   m_done [2];
  bit   m_turn [2];
  bit   m_wen [2];
  bit   m_rej [2];
  int   m_pos [2];
  int   m_mark [2];
  int   m_final [2];
  int   m_kprev [2];
  int   forfeit [2] = '{0, 1};

  task automatic model(input int i);
    bit ev;
    int c;
    if (rst) begin
      m_secs[i] = TS; m_sub[i] = 0; m_after[i] = 0;
      m_done[i] = 0; m_turn[i] = 0; m_wen[i] = 0; m_rej[i] = 0;
      m_pos[i] = 0; m_mark[i] = 0; m_final[i] = 0; m_kprev[i] = 0;
      return;
    end
    c = int'(key_code);
    ev = (c != 0) && (m_kprev[i] == 0);
    m_kprev[i] = c;
    m_wen[i] = 0;
    m_rej[i] = 0;
    if (m_done[i]) return;
    if (m_after[i] == 1) begin
      m_after[i] = 2;
    end else if (m_after[i] == 2) begin
      m_after[i] = 0;
      if (game_state != 2'b00) begin
        m_final[i] = int'(game_state);
        m_done[i] = 1;
      end else begin
        m_turn[i] = !m_turn[i];
        m_secs[i] = TS;
        m_sub[i] = 0;
      end
    end else if (ev && c >= 1 && c <= 9
                 && board[2*(c-1) +: 2] == 2'b00) begin
      m_pos[i] = c - 1;
      m_mark[i] = m_turn[i] ? 2 : 1;
      m_wen[i] = 1;
      m_after[i] = 1;
    end else begin
      m_rej[i] = ev;
      m_sub[i]++;
      if (m_sub[i] == TPS) begin
        m_sub[i] = 0;
        if (m_secs[i] == 0) begin
          if (forfeit[i] != 0) begin
            m_final[i] = m_turn[i] ? 1 : 2;
            m_done[i] = 1;
          end else begin
            m_turn[i] = !m_turn[i];
            m_secs[i] = TS;
          end
        end else begin
          m_secs[i]--;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int i,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL d%0d %s observed=%0h expected=%0h",
             i, tag, obs, exp);
    end
  endtask

  task automatic check_all(input int i);
    chk("wr_en", i, 32'(wr_en[i]), 32'(m_wen[i]));
    chk("wr_pos", i, 32'(wr_pos[i]), m_pos[i]);
    chk("wr_mark", i, 32'(wr_mark[i]), m_mark[i]);
    chk("whos_turn", i, 32'(whos_turn[i]), 32'(m_turn[i]));
    chk("time_tens", i, 32'(time_tens[i]), m_secs[i] / 10);
    chk("time_ones", i, 32'(time_ones[i]), m_secs[i] % 10);
    chk("key_reject", i, 32'(key_reject[i]), 32'(m_rej[i]));
    chk("final_state", i, 32'(final_state[i]), m_final[i]);
    chk("busy", i, 32'(busy[i]), 32'(m_after[i] != 0));
  endtask

  // one clock: models see the inputs sampled at this edge;
  // the recorder is emulated by marking the board after the checks
  task automatic step();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check_all(0);
    check_all(1);
    if (m_wen[0])
      board[2*m_pos[0] +: 2] = 2'(m_mark[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_code = 4'd0;
    board = 18'd0;
    game_state = 2'b00;
    step();
    rst = 1'b0;
  endtask

  function automatic bit board_full();
    for (int c = 0; c < 9; c++)
      if (board[2*c +: 2] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int pulses;
    int mode;
    int len;
    int r;

    // reset state and first tick
    do_reset();
    chk("rst_tens", 0, 32'(time_tens[0]), 1);
    chk("rst_ones", 0, 32'(time_ones[0]), 5);
    chk("rst_busy", 0, 32'(busy[0]), 0);
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      pulses += int'(wr_en[0]);
    end
    chk("idle_tens", 0, 32'(time_tens[0]), 1);
    chk("idle_ones", 0, 32'(time_ones[0]), 4);
    chk("idle_nowr", 0, pulses, 0);

    // held key 5 on empty board
    key_code = 4'd5;
    step();
    chk("k5_wr_en", 0, 32'(wr_en[0]), 1);
    chk("k5_pos", 0, 32'(wr_pos[0]), 4);
    chk("k5_mark", 0, 32'(wr_mark[0]), 1);
    pulses = 1;
    step();
    pulses += int'(wr_en[0]);
    chk("k5_turn_n2", 0, 32'(whos_turn[0]), 0);
    step();
    pulses += int'(wr_en[0]);
    chk("k5_turn_n3", 0, 32'(whos_turn[0]), 1);
    chk("k5_reload", 0, 32'(time_ones[0]), 5);
    for (int j = 0; j < 17; j++) begin
      step();
      pulses += int'(wr_en[0]);
    end
    chk("k5_pulses", 0, pulses, 1);

    // occupied cell and invalid code
    key_code = 4'd0; step();
    key_code = 4'd5; step();
    chk("occ_rej", 0, 32'(key_reject[0]), 1);
    chk("occ_nowr", 0, 32'(wr_en[0]), 0);
    step();
    chk("occ_rej_once", 0, 32'(key_reject[0]), 0);
    key_code = 4'd0; step();
    key_code = 4'd12; step();
    chk("inv_rej", 0, 32'(key_reject[0]), 1);
    key_code = 4'd0; step();
    chk("rej_turn", 0, 32'(whos_turn[0]), 1);

    // timeout: pass vs forfeit with O to move
    do_reset();
    for (int j = 0; j < 159; j++) step();
    chk("to_zero", 0, 32'({time_tens[0], time_ones[0]}), 0);
    step();
    chk("to_pass", 0, 32'(whos_turn[0]), 1);
    chk("to_reload", 0, 32'(time_tens[0]), 1);
    chk("to_forfeit", 1, 32'(final_state[1]), 2);
    key_code = 4'd1; step();
    chk("to_keyed0", 0, 32'(wr_en[0]), 1);
    chk("to_ignored1", 1, 32'(wr_en[1]), 0);
    key_code = 4'd0; step(); step();

    // winning move, then frozen until reset
    do_reset();
    game_state = 2'b01;
    key_code = 4'd3; step();
    key_code = 4'd0; step(); step();
    chk("win_final", 0, 32'(final_state[0]), 1);
    chk("win_final1", 1, 32'(final_state[1]), 1);
    game_state = 2'b00;
    pulses = 0;
    for (int j = 0; j < 6; j++) begin
      key_code = (j % 2 == 0) ? 4'd7 : 4'd0;
      step();
      pulses += int'(wr_en[0]);
    end
    chk("done_nowr", 0, pulses, 0);
    do_reset();
    chk("rst_turn", 0, 32'(whos_turn[0]), 0);
    chk("rst_final", 0, 32'(final_state[0]), 0);

    // key lands on the timeout tick
    for (int j = 0; j < 159; j++) step();
    key_code = 4'd2; step();
    chk("race_wr0", 0, 32'(wr_en[0]), 1);
    chk("race_wr1", 1, 32'(wr_en[1]), 1);
    chk("race_nofo", 1, 32'(final_state[1]), 0);
    key_code = 4'd0; step(); step();
    chk("race_turn", 0, 32'(whos_turn[0]), 1);

    // random play
    for (int s = 0; s < 40; s++) begin
      mode = int'($urandom % 4);
      len = (mode == 0) ? 100 + int'($urandom % 80)
                        : 20 + int'($urandom % 40);
      for (int j = 0; j < len; j++) begin
        rst = 1'b0;
        if (($urandom % 400) == 0 || board_full()
            || (m_done[0] && m_done[1] && ($urandom % 8) == 0)) begin
          rst = 1'b1;
          board = 18'd0;
          key_code = 4'd0;
        end else begin
          r = int'($urandom % 20);
          if (mode == 0 || r < 5) key_code = 4'd0;
          else if (r < 8) key_code = 4'($urandom);
        end
        game_state = (($urandom % 6) == 0)
                     ? 2'($urandom_range(1, 3)) : 2'b00;
        step();
      end
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Central game controller for the tic-tac-toe system.
- Accepts keypad cell selections, validates them against current board occupancy, issues one-cycle write strobes to the mark recorder, and runs the per-turn countdown timer as BCD digits.
- Waits for the win checker's verdict before alternating turns; handles turn timeout.
- Sits between the keypad buffer, the board recorder and the game-over checker; replaces ad-hoc turn/timer logic.

Parameters:
- TICKS_PER_SEC, 10: clk cycles per second (clk is 10 Hz in system).
- TURN_SECONDS, 15: per-turn timer reload value; legal range 1..99, loaded as BCD.
- TIMEOUT_FORFEIT, 0: 0 = timeout passes turn to opponent; 1 = timeout ends game, opponent wins.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- key_code  input  4  keypad buffer: 0 = no key, 1..9 = cell 0..8, 10..15 = invalid.
- board  input  18  packed board; cell i at [2i+1:2i]; 00 empty, 01 O, 10 X.
- game_state  input  2  checker verdict: 00 running, 01 O wins, 10 X wins, 11 draw.
- wr_en  output  1  one-cycle write strobe to recorder.
- wr_pos  output  4  cell index 0..8, valid when wr_en.
- wr_mark  output  2  01 O, 10 X, valid when wr_en.
- whos_turn  output  1  0 = O, 1 = X.
- time_tens  output  4  BCD tens digit of remaining time.
- time_ones  output  4  BCD ones digit.
- key_reject  output  1  one-cycle pulse when an accepted key edge is invalid/occupied.
- final_state  output  2  00 running, 01 O won, 10 X won, 11 draw; includes forfeit result.
- busy  output  1  high in WRITE/CHECK.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - State TURN; whos_turn=0; timer loaded with TURN_SECONDS (15 -> tens=1, ones=5); prescaler=0.
  - wr_en=0, wr_pos=0, wr_mark=00, key_reject=0, final_state=00, busy=0, key_prev=0.
  - Reset mid-game aborts any pending write.
- Key edge: key event = key_code!=0 while registered key_prev==0. key_prev updates every cycle in all states. A held key yields exactly one event.
- Prescaler: counts 0..TICKS_PER_SEC-1 in TURN only; tick when it wraps to 0.
- Timer decrement on tick: ones-1; if ones==0 then ones=9, tens-1. Value 00 is displayed for one full second.
- Timeout: a tick while timer==00.
- TURN, key event:
  - Valid (code 1..9 and board cell code-1 == 00): register wr_pos=code-1, wr_mark = whos_turn ? 10 : 01; next state WRITE.
  - Otherwise: key_reject=1 for one cycle; remain in TURN; timer unaffected.
- TURN, timeout:
  - TIMEOUT_FORFEIT=0: toggle whos_turn, reload timer, prescaler=0, stay in TURN.
  - TIMEOUT_FORFEIT=1: final_state = whos_turn ? 01 : 10; go to DONE.
- Valid key and timeout tick in the same cycle: key wins; timeout is discarded.
- WRITE (1 cycle): wr_en=1, busy=1; next CHECK. Timer frozen.
- CHECK (1 cycle, recorder and checker settle): busy=1.
  - game_state!=00: final_state=game_state; go to DONE.
  - Else: toggle whos_turn, reload timer, prescaler=0; go to TURN.
- Latency: key edge at cycle n -> wr_en high in cycle n+1 -> turn switch visible in cycle n+3.
- DONE: all keys ignored, timer frozen, wr_en=0; hold until rst.
- Key events in WRITE/CHECK/DONE are dropped, not queued.
- All outputs registered.

Test Plan:
- Reset then idle 10 cycles -> tens=1, ones=4 after first tick; whos_turn=0; wr_en never asserted.
- key_code 5 held 20 cycles on empty board -> single wr_en pulse, wr_pos=4, wr_mark=01; whos_turn=1 three cycles after edge; timer reloaded to 15.
- Press 5 again with board[9:8]=01 -> key_reject pulses once, no wr_en, whos_turn unchanged; key 12 -> key_reject.
- No key for 16 s (160 cycles) with TIMEOUT_FORFEIT=0 -> whos_turn toggles at the tick after 00; timer back to 15. With TIMEOUT_FORFEIT=1 and O to move -> final_state=10, keys then ignored.
- Winning move: drive game_state=01 in CHECK -> final_state=01, DONE; later keys produce no wr_en; rst returns to TURN, whos_turn=0, final_state=00.
- Key edge on the same cycle as a timeout tick (timer 00, prescaler 9) -> write occurs, no forfeit or pass.
